wb_select_queue: RTL and testbench

- Parametrised successor to the writeback data selector of the multicycle MIPS datapath.
- Selects one of NUM_SRC 32-bit datapath sources, or a constant, per writeback command, then captures the result with its destination register in a small in-order queue.
- The register file drains the queue under a valid/ready handshake.
- Also provides youngest-first forwarding of queued-but-unwritten results and a sticky illegal-selector flag.

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_src_select.sv | 37 +++
 rtl/wb_select_queue.sv | 130 +++++++++++++
 tb/tb_wb_select_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback select queue: source indices,
// default constant and the default-width queue entry layout.
package wb_pkg;

  // Writeback source indices on the flattened src_data bus
  localparam int SRC_ALU      = 0;
  localparam int SRC_LOADSIZE = 1;
  localparam int SRC_HI       = 2;
  localparam int SRC_LO       = 3;
  localparam int SRC_EXT1     = 4;
  localparam int SRC_EXT16    = 5;
  localparam int SRC_SLEFT16  = 6;
  localparam int SRC_SHIFT    = 7;
  localparam int SRC_CONST    = 8;
  localparam int SRC_A        = 9;
  localparam int SRC_B        = 10;

  // Constant returned when the selector picks SRC_CONST
  localparam int WB_CONST_VAL = 227;

  // Default datapath and register-address widths
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // One queued writeback: result data plus destination register
  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_ADDR_W-1:0] addr;
  } wb_entry_t;

endpackage

// File: rtl/wb_src_select.sv
// Combinational writeback source selector. Picks one of NUM_SRC slices or
// the constant; any selector outside that set yields 0 and flags illegal.
module wb_src_select
  import wb_pkg::*;
#(
  parameter int NUM_SRC   = 11,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 4,
  parameter int CONST_SEL = SRC_CONST,
  parameter int CONST_VAL = WB_CONST_VAL
) (
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         data,
  output logic                      illegal
);

  localparam logic [SEL_W-1:0]  CSEL = SEL_W'(CONST_SEL);
  localparam logic [DATA_W-1:0] CVAL = DATA_W'(CONST_VAL);

  // Constant selector is checked last so it overrides a source at that index
  always_comb begin
    data    = '0;
    illegal = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        data    = src_data[k*DATA_W +: DATA_W];
        illegal = 1'b0;
      end
    end
    if (sel == CSEL) begin
      data    = CVAL;
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/wb_select_queue.sv
// Writeback selector feeding a small in-order queue drained by the register
// file, with youngest-first forwarding of pending results and a sticky
// illegal-selector flag.
module wb_select_queue
  import wb_pkg::*;
#(
  parameter int NUM_SRC   = 11,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 4,
  parameter int CONST_SEL = SRC_CONST,
  parameter int CONST_VAL = WB_CONST_VAL,
  parameter int DEPTH     = 2,
  parameter int ADDR_W    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [ADDR_W-1:0]         in_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ADDR_W-1:0]         out_addr,
  output logic                      out_we,
  input  logic [ADDR_W-1:0]         fwd_addr,
  output logic                      fwd_hit,
  output logic [DATA_W-1:0]         fwd_data,
  output logic                      err_illegal,
  input  logic                      err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             last_q;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_illegal;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  wb_src_select #(
    .NUM_SRC   (NUM_SRC),
    .DATA_W    (DATA_W),
    .SEL_W     (SEL_W),
    .CONST_SEL (CONST_SEL),
    .CONST_VAL (CONST_VAL)
  ) u_sel (
    .src_data (src_data),
    .sel      (in_sel),
    .data     (sel_data),
    .illegal  (sel_illegal)
  );

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && out_ready;

  // While empty the head shows the last retired entry (zero after reset)
  assign out_valid = !empty;
  assign out_data  = empty ? last_q.data : mem[rd_ptr].data;
  assign out_addr  = empty ? last_q.addr : mem[rd_ptr].addr;
  assign out_we    = out_valid && (out_addr != '0);

  // Queue storage: written on accept only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: sel_data, addr: in_addr};
    end
  end

  // Pointers, occupancy, last-retired entry and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      last_q      <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
      if (push && sel_illegal) begin
        err_illegal <= 1'b1;
      end else if (err_clr) begin
        err_illegal <= 1'b0;
      end
    end
  end

  // Walk stored entries oldest to youngest so the youngest match wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int a = 0; a < DEPTH; a++) begin
      idx = rd_ptr + PTR_W'(a);
      if ((CNT_W'(a) < cnt) && (fwd_addr != '0) && (mem[idx].addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem[idx].data;
      end
    end
  end

endmodule

// File: tb/tb_wb_select_queue.sv
// Directed bench for wb_select_queue at default parameters (DEPTH=2).
module tb_wb_select_queue;

  localparam int NUM_SRC = 11;
  localparam int DATA_W  = 32;
  localparam int SEL_W   = 4;
  localparam int ADDR_W  = 5;

  logic                      clk;
  logic                      reset;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          in_sel;
  logic [ADDR_W-1:0]         in_addr;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [ADDR_W-1:0]         out_addr;
  logic                      out_we;
  logic [ADDR_W-1:0]         fwd_addr;
  logic                      fwd_hit;
  logic [DATA_W-1:0]         fwd_data;
  logic                      err_illegal;
  logic                      err_clr;

  int checks = 0;
  int errors = 0;

  wb_select_queue dut (
    .clk         (clk),
    .reset       (reset),
    .src_data    (src_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_addr     (in_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_we      (out_we),
    .fwd_addr    (fwd_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .err_illegal (err_illegal),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int k, input logic [31:0] v);
    src_data[k*DATA_W +: DATA_W] = v;
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    src_data  = '0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_addr   = '0;
    out_ready = 1'b0;
    fwd_addr  = '0;
    err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_err", err_illegal, 0);
    reset = 1'b1;
    step();

    // Basic push/pop: slice 0, addr 5
    set_src(0, 32'h0000_0011);
    in_sel = 4'd0; in_addr = 5'd5; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("no_bypass", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'h11);
    chk("t1_addr", out_addr, 5);
    chk("t1_we", out_we, 1);
    step();
    chk("t1_empty", out_valid, 0);
    chk("t1_hold_data", out_data, 32'h11);
    chk("t1_hold_addr", out_addr, 5);

    // Constant selector overrides slice 8
    for (int k = 0; k < NUM_SRC; k++) set_src(k, 32'hFFFF_FFFF);
    out_ready = 1'b0;
    in_sel = 4'd8; in_addr = 5'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("const_data", out_data, 32'h0000_00E3);
    chk("const_addr", out_addr, 3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("const_drained", out_valid, 0);

    // Fill to full, hold third command, then drain
    set_src(1, 32'h101); set_src(2, 32'h202); set_src(3, 32'h303);
    in_valid = 1'b1; in_sel = 4'd1; in_addr = 5'd1;
    step();
    chk("fill1_ready", in_ready, 1);
    in_sel = 4'd2; in_addr = 5'd2;
    step();
    chk("fill2_ready", in_ready, 0);
    in_sel = 4'd3; in_addr = 5'd4;
    step();
    chk("held_ready", in_ready, 0);
    chk("held_head", out_data, 32'h101);
    chk("held_head_addr", out_addr, 1);
    out_ready = 1'b1;
    step();
    chk("pop1_ready", in_ready, 1);
    chk("pop1_head", out_data, 32'h202);
    step();
    in_valid = 1'b0;
    chk("pushpop_valid", out_valid, 1);
    chk("pushpop_head", out_data, 32'h303);
    chk("pushpop_addr", out_addr, 4);
    step();
    chk("drain_empty", out_valid, 0);
    chk("drain_ready", in_ready, 1);

    // Forwarding: youngest of two matching entries wins
    out_ready = 1'b0;
    set_src(0, 32'hA);
    in_valid = 1'b1; in_sel = 4'd0; in_addr = 5'd7;
    step();
    set_src(0, 32'hB);
    step();
    in_valid = 1'b0;
    fwd_addr = 5'd7;
    #1;
    chk("fwd_hit", fwd_hit, 1);
    chk("fwd_youngest", fwd_data, 32'hB);
    fwd_addr = 5'd9;
    #1;
    chk("fwd_miss_hit", fwd_hit, 0);
    chk("fwd_miss_data", fwd_data, 0);
    fwd_addr = 5'd7;
    out_ready = 1'b1;
    step();
    chk("fwd_after_pop", fwd_data, 32'hB);
    step();
    out_ready = 1'b0;
    chk("fwd_empty", fwd_hit, 0);

    // Pushed command not visible to forwarding until stored
    in_valid = 1'b1; in_sel = 4'd0; in_addr = 5'd7;
    #1;
    chk("fwd_push_invisible", fwd_hit, 0);
    step();
    chk("fwd_push_stored", fwd_hit, 1);

    // Register 0 entry: queued, no forward hit, drains without write enable
    set_src(10, 32'h5A);
    in_sel = 4'd10; in_addr = 5'd0;
    step();
    in_valid = 1'b0;
    fwd_addr = 5'd0;
    #1;
    chk("fwd_r0", fwd_hit, 0);
    out_ready = 1'b1;
    step();
    chk("r0_valid", out_valid, 1);
    chk("r0_data", out_data, 32'h5A);
    chk("r0_we", out_we, 0);
    step();
    chk("r0_drained", out_valid, 0);

    // Illegal selectors and sticky error flag
    in_valid = 1'b1; in_sel = 4'd15; in_addr = 5'd6;
    step();
    in_valid = 1'b0;
    chk("ill15_err", err_illegal, 1);
    chk("ill15_data", out_data, 0);
    chk("ill15_valid", out_valid, 1);
    step();
    chk("err_sticky", err_illegal, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", err_illegal, 0);
    in_valid = 1'b1; in_sel = 4'd11; in_addr = 5'd6;
    step();
    in_valid = 1'b0;
    chk("ill11_err", err_illegal, 1);
    in_valid = 1'b1; in_sel = 4'd12; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("set_beats_clr", err_illegal, 1);
    chk("ill12_data", out_data, 0);
    step();

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    set_src(0, 32'hB);
    in_valid = 1'b1; in_sel = 4'd0; in_addr = 5'd7;
    step();
    step();
    in_valid = 1'b0; fwd_addr = 5'd7;
    #1;
    chk("pre_rst_full", in_ready, 0);
    chk("pre_rst_fwd", fwd_hit, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_fwd", fwd_hit, 0);
    chk("arst_err", err_illegal, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_data", out_data, 0);
    reset = 1'b1;
    step();
    chk("post_rst_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
